// File: rtl/bp_update_queue.sv
// Commit-side update queue for the branch predictor's single PHT write port.
// Accepts up to two resolved branches per cycle, drains one per cycle, drops the youngest on overflow.
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c0_valid,
    input  logic [31:0]              c0_pc,
    input  logic                     c0_taken,
    input  logic                     c1_valid,
    input  logic [31:0]              c1_pc,
    input  logic                     c1_taken,
    input  logic                     bp_busy,
    output logic                     bp_w_en,
    output logic [31:0]              bp_commit_pc,
    output logic                     bp_taken,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic            pop;
    logic            acc0;
    logic            acc1;
    logic [CW-1:0]   free;
    logic [PW-1:0]   wr1_idx;
    logic [1:0]      drops;
    logic [CNT_W:0]  drop_sum;

    always_comb begin
        pop  = (count_q != '0) && !bp_busy;
        // A pop in this cycle frees its slot for a push in the same cycle.
        free = CW'(DEPTH) - count_q + CW'(pop);
        acc0 = c0_valid && (free >= CW'(1));
        acc1 = c1_valid && (free >= (CW'(1) + CW'(acc0)));

        // Slot 1 lands right after slot 0, or at tail when slot 0 was not taken.
        wr1_idx = tail_q + PW'(acc0);

        mem_d = mem_q;
        if (acc0) begin
            mem_d[tail_q] = '{pc: c0_pc, taken: c0_taken};
        end
        if (acc1) begin
            mem_d[wr1_idx] = '{pc: c1_pc, taken: c1_taken};
        end

        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(acc0) + PW'(acc1);
        count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);

        drops    = 2'(c0_valid && !acc0) + 2'(c1_valid && !acc1);
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drops);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Payload storage needs no reset; count_q gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        bp_w_en      = pop;
        bp_commit_pc = '0;
        bp_taken     = 1'b0;
        if (count_q != '0) begin
            bp_commit_pc = mem_q[head_q].pc;
            bp_taken     = mem_q[head_q].taken;
        end
        occupancy = count_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: in-order predictor writes, overflow drops, wrap and async reset.
module tb_bp_update_queue;

    logic        clk;
    logic        rst;
    logic        c0_valid;
    logic [31:0] c0_pc;
    logic        c0_taken;
    logic        c1_valid;
    logic [31:0] c1_pc;
    logic        c1_taken;
    logic        bp_busy;

    logic        bp_w_en;
    logic [31:0] bp_commit_pc;
    logic        bp_taken;
    logic [3:0]  occupancy;
    logic [15:0] drop_cnt;

    logic        sat_w_en;
    logic [31:0] sat_pc;
    logic        sat_taken;
    logic [3:0]  sat_occ;
    logic [3:0]  sat_drop;

    int total = 0;
    int bad = 0;
    int writes_seen = 0;
    logic [32:0] exp_q[$];

    bp_update_queue #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_taken(c0_taken),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_taken(c1_taken),
        .bp_busy(bp_busy),
        .bp_w_en(bp_w_en), .bp_commit_pc(bp_commit_pc), .bp_taken(bp_taken),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    // Narrow drop counter copy, fed identically, to see saturation.
    bp_update_queue #(.DEPTH(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_taken(c0_taken),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_taken(c1_taken),
        .bp_busy(bp_busy),
        .bp_w_en(sat_w_en), .bp_commit_pc(sat_pc), .bp_taken(sat_taken),
        .occupancy(sat_occ), .drop_cnt(sat_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic t);
        exp_q.push_back({pc, t});
    endtask

    task automatic drive(input logic v0, input logic [31:0] p0, input logic t0,
                         input logic v1, input logic [31:0] p1, input logic t1);
        c0_valid = v0; c0_pc = p0; c0_taken = t0;
        c1_valid = v1; c1_pc = p1; c1_taken = t1;
        @(posedge clk);
        #1;
        c0_valid = 1'b0; c0_pc = '0; c0_taken = 1'b0;
        c1_valid = 1'b0; c1_pc = '0; c1_taken = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || occupancy != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 64'((exp_q.size() == 0) && (occupancy == 0)), 64'd1);
    endtask

    // Scoreboard: every predictor write is compared against the expected queue.
    always @(negedge clk) begin
        if (rst && bp_w_en) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {31'd0, bp_commit_pc, bp_taken}, 64'h0);
            end else begin
                check("wr_entry", {31'd0, bp_commit_pc, bp_taken}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; bp_busy = 1'b0;
        c0_valid = 1'b0; c0_pc = '0; c0_taken = 1'b0;
        c1_valid = 1'b0; c1_pc = '0; c1_taken = 1'b0;

        // Reset then single update.
        repeat (3) @(posedge clk);
        #1;
        check("rst_w_en", 64'(bp_w_en), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_pc", 64'(bp_commit_pc), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b1;
        push_exp(32'h0000_1004, 1'b1);
        drive(1'b1, 32'h0000_1004, 1'b1, 1'b0, 32'h0, 1'b0);
        check("single_occ1", 64'(occupancy), 64'd1);
        check("single_w_en", 64'(bp_w_en), 64'd1);
        check("single_pc", 64'(bp_commit_pc), 64'h1004);
        check("single_taken", 64'(bp_taken), 64'd1);
        @(posedge clk);
        #1;
        check("single_occ0", 64'(occupancy), 64'd0);
        check("single_idle", 64'(bp_w_en), 64'd0);
        check("single_idle_pc", 64'(bp_commit_pc), 64'd0);

        // Dual commit ordering, then slot 1 alone.
        writes_seen = 0;
        push_exp(32'h100, 1'b0);
        push_exp(32'h104, 1'b1);
        drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h104, 1'b1);
        check("dual_occ", 64'(occupancy), 64'd2);
        check("dual_head", 64'(bp_commit_pc), 64'h100);
        drain(10);
        check("dual_count", 64'(writes_seen), 64'd2);
        writes_seen = 0;
        push_exp(32'h104, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h104, 1'b0);
        check("c1only_pc", 64'(bp_commit_pc), 64'h104);
        drain(10);
        check("c1only_count", 64'(writes_seen), 64'd1);

        // Overflow under backpressure: the youngest two are dropped.
        bp_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                push_exp(32'h200 + 32'(8 * i), 1'b0);
                push_exp(32'h204 + 32'(8 * i), 1'b1);
            end
            drive(1'b1, 32'h200 + 32'(8 * i), 1'b0, 1'b1, 32'h204 + 32'(8 * i), 1'b1);
        end
        check("ovf_occ", 64'(occupancy), 64'd8);
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        check("ovf_sat_drop", 64'(sat_drop), 64'd2);
        check("ovf_busy_w_en", 64'(bp_w_en), 64'd0);
        writes_seen = 0;
        bp_busy = 1'b0;
        drain(20);
        check("ovf_wr_count", 64'(writes_seen), 64'd8);

        // Full with a same-cycle pop: one accepted, one dropped.
        bp_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h400 + 32'(8 * i), 1'b1);
            push_exp(32'h404 + 32'(8 * i), 1'b0);
            drive(1'b1, 32'h400 + 32'(8 * i), 1'b1, 1'b1, 32'h404 + 32'(8 * i), 1'b0);
        end
        check("refill_occ", 64'(occupancy), 64'd8);
        writes_seen = 0;
        bp_busy = 1'b0;
        push_exp(32'h500, 1'b1);
        drive(1'b1, 32'h500, 1'b1, 1'b1, 32'h504, 1'b0);
        check("fullpop_occ", 64'(occupancy), 64'd8);
        check("fullpop_drop", 64'(drop_cnt), 64'd3);
        drain(20);
        check("fullpop_wr_count", 64'(writes_seen), 64'd9);

        // Pointer wrap: dual bursts separated by an idle cycle, many laps of the ring.
        writes_seen = 0;
        for (int i = 0; i < 20; i++) begin
            push_exp(32'h1000_0000 + 32'(8 * i), i[0]);
            push_exp(32'h1000_0004 + 32'(8 * i), ~i[0]);
            drive(1'b1, 32'h1000_0000 + 32'(8 * i), i[0], 1'b1, 32'h1000_0004 + 32'(8 * i), ~i[0]);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        drain(20);
        check("wrap_wr_count", 64'(writes_seen), 64'd40);
        check("wrap_drop", 64'(drop_cnt), 64'd3);

        // Async reset between edges with 5 entries queued.
        bp_busy = 1'b1;
        push_exp(32'h600, 1'b1); push_exp(32'h604, 1'b0);
        drive(1'b1, 32'h600, 1'b1, 1'b1, 32'h604, 1'b0);
        push_exp(32'h608, 1'b1); push_exp(32'h60c, 1'b1);
        drive(1'b1, 32'h608, 1'b1, 1'b1, 32'h60c, 1'b1);
        push_exp(32'h610, 1'b0);
        drive(1'b1, 32'h610, 1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_occ", 64'(occupancy), 64'd5);
        bp_busy = 1'b0;
        #1;
        check("pre_rst_w_en", 64'(bp_w_en), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_w_en", 64'(bp_w_en), 64'd0);
        check("async_occ", 64'(occupancy), 64'd0);
        check("async_pc", 64'(bp_commit_pc), 64'd0);
        check("async_drop", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Saturation: 20 drops into a 4-bit counter.
        bp_busy = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 4) begin
                push_exp(32'h700 + 32'(8 * i), 1'b0);
                push_exp(32'h704 + 32'(8 * i), 1'b1);
            end
            drive(1'b1, 32'h700 + 32'(8 * i), 1'b0, 1'b1, 32'h704 + 32'(8 * i), 1'b1);
        end
        check("sat_occ", 64'(occupancy), 64'd8);
        check("sat_drop_wide", 64'(drop_cnt), 64'd20);
        check("sat_drop_narrow", 64'(sat_drop), 64'd15);
        writes_seen = 0;
        bp_busy = 1'b0;
        drain(20);
        check("sat_wr_count", 64'(writes_seen), 64'd8);
        check("sat_hold", 64'(sat_drop), 64'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
